ssd_scanner: RTL and testbench

Downstream display stage for the queue-management system. It takes the four 5-bit display codes produced by the bank core (`ssd0`–`ssd3`) and time-multiplexes them onto a common 4-digit seven-segment display. It provides refresh scanning, per-frame snapshotting to prevent tearing, anti-ghost blanking between digits, and whole-display blinking driven by the core's `Wait` flag.

---
 rtl/ssd_scanner.sv | 151 +++++++++++++++
 tb/tb_ssd_scanner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_scanner
//  Purpose  : Time-multiplexes four 5-bit display codes onto a common-anode
//             4-digit seven-segment display. Features refresh scanning,
//             per-frame snapshotting (no tearing), anti-ghost blanking at
//             the start of every digit slot and whole-display blinking.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             ssd0..ssd3 [4:0]   - display codes, ssd0 = rightmost digit
//             dp_mask    [3:0]   - active-high decimal point per digit
//             blink              - blink the whole display while high
//             an         [3:0]   - active-low digit enables (registered)
//             seg        [6:0]   - active-low segments {g,f,e,d,c,b,a}
//             dp                 - active-low decimal point (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module ssd_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYC    = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ssd0,
    input  logic [4:0] ssd1,
    input  logic [4:0] ssd2,
    input  logic [4:0] ssd3,
    input  logic [3:0] dp_mask,
    input  logic       blink,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int c_CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_CW-1:0] c_CNT_MAX   = c_CW'(REFRESH_DIV - 1);
    localparam logic [c_CW-1:0] c_BLANK     = c_CW'(BLANK_CYC);
    localparam logic [c_FW-1:0] c_FRAME_MAX = c_FW'(BLINK_FRAMES - 1);

    localparam logic [4:0] c_CODE_BLANK = 5'h10;
    localparam logic [6:0] c_SEG_OFF    = 7'b1111111;

    // r_cnt / r_dig hold the scan position of the edge about to occur;
    // outputs registered on that edge reflect this position.
    logic [c_CW-1:0]  r_cnt;
    logic [1:0]       r_dig;
    logic [3:0][4:0]  r_code;
    logic [3:0]       r_dp;
    logic [c_FW-1:0]  r_fcnt;
    logic             r_phase;   // blink phase for the next frame, 1 = on
    logic             r_show;    // current frame lit (latched at frame start)

    logic             w_frame_start;
    logic             w_slot_end;
    logic             w_lit;
    logic [3:0]       w_an;
    logic [6:0]       w_glyph;

    function automatic logic [6:0] f_glyph(input logic [4:0] code);
        logic [6:0] g;
        g = c_SEG_OFF;
        case (code)
            5'h00: g = 7'b1000000;
            5'h01: g = 7'b1111001;
            5'h02: g = 7'b0100100;
            5'h03: g = 7'b0110000;
            5'h04: g = 7'b0011001;
            5'h05: g = 7'b0010010;
            5'h06: g = 7'b0000010;
            5'h07: g = 7'b1111000;
            5'h08: g = 7'b0000000;
            5'h09: g = 7'b0010000;
            5'h0A: g = 7'b0001000;
            5'h0B: g = 7'b0000011;
            5'h0C: g = 7'b1000110;
            5'h0D: g = 7'b0100001;
            5'h0E: g = 7'b0000110;
            5'h0F: g = 7'b0001110;
            5'h11: g = 7'b0111111;   // dash
            5'h12: g = 7'b0001100;   // 'P'
            default: g = c_SEG_OFF;  // 0x10 and 0x13-0x1F are blank
        endcase
        return g;
    endfunction

    always_comb begin
        w_frame_start = (r_cnt == '0) && (r_dig == 2'd0);
        w_slot_end    = (r_cnt == c_CNT_MAX);
        // Blink is judged from r_show, which only changes at a frame start
        // where the output is blank anyway, so no slot is partially blanked.
        w_lit         = (r_cnt >= c_BLANK) && r_show;
        w_an          = ~(4'b0001 << r_dig);
        w_glyph       = f_glyph(r_code[r_dig]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_dig   <= 2'd0;
            r_code  <= {4{c_CODE_BLANK}};
            r_dp    <= 4'b0000;
            r_fcnt  <= '0;
            r_phase <= 1'b1;
            r_show  <= 1'b1;
            an      <= 4'b1111;
            seg     <= c_SEG_OFF;
            dp      <= 1'b1;
        end else begin
            if (w_lit) begin
                an  <= w_an;
                seg <= w_glyph;
                dp  <= ~r_dp[r_dig];
            end else begin
                an  <= 4'b1111;
                seg <= c_SEG_OFF;
                dp  <= 1'b1;
            end

            if (w_slot_end) begin
                r_cnt <= '0;
                r_dig <= r_dig + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_frame_start) begin
                r_code <= {ssd3, ssd2, ssd1, ssd0};
                r_dp   <= dp_mask;
                if (blink) begin
                    // The frame starting now uses the current phase; the
                    // counter then records it as one more frame of this run.
                    r_show <= r_phase;
                    if (r_fcnt == c_FRAME_MAX) begin
                        r_fcnt  <= '0;
                        r_phase <= ~r_phase;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end else begin
                    r_show  <= 1'b1;
                    r_fcnt  <= '0;
                    r_phase <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ssd_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ssd_scanner
//  Purpose  : Self-checking bench for ssd_scanner. A reference model derives
//             the expected {an,seg,dp} for every edge from the edge number
//             since reset; a monitor compares against the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_scanner;

    localparam int c_RD = 4;
    localparam int c_BC = 1;
    localparam int c_BF = 2;

    logic       clk;
    logic       rst;
    logic [4:0] ssd0, ssd1, ssd2, ssd3;
    logic [3:0] dp_mask;
    logic       blink;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    ssd_scanner #(
        .REFRESH_DIV  (c_RD),
        .BLANK_CYC    (c_BC),
        .BLINK_FRAMES (c_BF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ssd0    (ssd0),
        .ssd1    (ssd1),
        .ssd2    (ssd2),
        .ssd3    (ssd3),
        .dp_mask (dp_mask),
        .blink   (blink),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [11:0] val;   // {an, seg, dp}
        int          edge_n;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;

    bit          m_en = 0;
    int          m_n = 0;          // edge number since reset
    logic [4:0]  m_code[4];
    logic [3:0]  m_dp;
    int          m_run = 0;        // frames elapsed with blink held high
    bit          m_lit = 1;

    function automatic logic [6:0] glyph(input logic [4:0] c);
        logic [6:0] hex_tab [16];
        hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        if (c < 5'h10)  return hex_tab[c[3:0]];
        if (c == 5'h11) return 7'b0111111;
        if (c == 5'h12) return 7'b0001100;
        return 7'b1111111;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        int   pos, slot, d;
        logic [3:0] ea;
        if (rst) begin
            m_en  = 1;
            m_n   = 0;
            for (int i = 0; i < 4; i++) m_code[i] = 5'h10;
            m_dp  = 4'b0000;
            m_run = 0;
            m_lit = 1;
            e.val = {4'b1111, 7'b1111111, 1'b1};
            e.edge_n = -1;
            exp_q.push_back(e);
        end else if (m_en) begin
            pos  = m_n % c_RD;
            slot = m_n / c_RD;
            d    = slot % 4;
            if (pos == 0 && d == 0) begin
                m_code[0] = ssd0; m_code[1] = ssd1;
                m_code[2] = ssd2; m_code[3] = ssd3;
                m_dp = dp_mask;
                if (blink) begin
                    m_lit = ((m_run / c_BF) % 2) == 0;
                    m_run++;
                end else begin
                    m_lit = 1;
                    m_run = 0;
                end
            end
            if (pos < c_BC || !m_lit) begin
                e.val = {4'b1111, 7'b1111111, 1'b1};
            end else begin
                ea = 4'b1111;
                ea[d] = 1'b0;
                e.val = {ea, glyph(m_code[d]), ~m_dp[d]};
            end
            e.edge_n = m_n;
            exp_q.push_back(e);
            m_n++;
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} === e.val) begin
                passes++;
            end else begin
                $display("FAIL scan edge=%0d t=%0t got an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                         e.edge_n, $time, an, seg, dp, e.val[11:8], e.val[7:1], e.val[0]);
            end
        end else if (m_en) begin
            checks++;
            $display("FAIL model_queue t=%0t got empty queue required one entry", $time);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; blink = 1'b0; dp_mask = 4'b0000;
        ssd0 = 5'h10; ssd1 = 5'h10; ssd2 = 5'h10; ssd3 = 5'h10;
        tick(3);
        rst = 1'b0;

        // Blank codes through the first frame, then a scan pattern.
        tick(4 * c_RD);
        do_reset();
        ssd0 = 5'h00; ssd1 = 5'h01; ssd2 = 5'h08; ssd3 = 5'h12;
        dp_mask = 4'b0100;
        tick(6);                 // edges 0..5 done
        ssd1 = 5'h11;            // must not appear until the next frame
        tick(3 * 4 * c_RD);

        // Blink from reset for six frames.
        blink = 1'b1;
        do_reset();
        tick(6 * 4 * c_RD);

        // Blink dropped during frame 2.
        do_reset();
        tick(2 * 4 * c_RD + 5);
        blink = 1'b0;
        tick(2 * 4 * c_RD);

        // Mid-slot reset at cnt=2 of slot 2, then scan restarts blank.
        do_reset();
        tick(2 * c_RD + 2);
        do_reset();
        tick(4 * c_RD + 4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)  ssd0 = 5'($urandom);
            if ($urandom_range(0, 7) == 0)  ssd1 = 5'($urandom);
            if ($urandom_range(0, 7) == 0)  ssd2 = 5'($urandom);
            if ($urandom_range(0, 7) == 0)  ssd3 = 5'($urandom);
            if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 63) == 0) blink = ~blink;
            rst = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
